// File: rtl/mem_responder.sv
// Byte-wide memory responder: req/ack handshake, programmable wait states,
// single read/write and wrapping burst reads from an internal storage array.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int BURST_LEN   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wren,
    input  logic              burst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int WCNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam int BCNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_LEN - 1);
    localparam int DEPTH = 1 << ADDR_W;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wren_q, wren_d;
    logic                burst_q, burst_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Next-state, capture and read-beat logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = wren_q;
        burst_d    = burst_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        mem_we_s   = 1'b0;
        // Burst addresses wrap naturally at the top of the array
        rd_addr_s  = addr_q + ADDR_W'(beat_cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d     = address;
                    wdata_d    = wdata;
                    wren_d     = wren;
                    burst_d    = burst & ~wren;
                    wait_cnt_d = '0;
                    beat_cnt_d = '0;
                    state_d    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_XFER;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_XFER;
                end else begin
                    state_d    = ST_WAIT;
                end
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
            ST_XFER: begin
                if (wren_q) begin
                    mem_we_s = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    rdata_d  = mem_q[rd_addr_s];
                    rvalid_d = 1'b1;
                    if (!burst_q || (beat_cnt_q == BEAT_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_DONE);
    end

    // Control, captured request and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            burst_q    <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            burst_q    <= burst_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage array keeps its contents across reset
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign busy   = busy_q;
    assign ack    = ack_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: u1 runs with one wait state, u0 with none.
`timescale 1ns/1ps
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, wren, burst;
    logic [7:0] address, wdata;
    logic       busy0, ack0, rvalid0, busy1, ack1, rvalid1;
    logic [7:0] rdata0, rdata1;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .BURST_LEN(4)) u0 (
        .clock(clk), .reset(reset), .req(req0), .wren(wren), .burst(burst),
        .address(address), .wdata(wdata), .busy(busy0), .ack(ack0),
        .rvalid(rvalid0), .rdata(rdata0));

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .BURST_LEN(4)) u1 (
        .clock(clk), .reset(reset), .req(req1), .wren(wren), .burst(burst),
        .address(address), .wdata(wdata), .busy(busy1), .ack(ack1),
        .rvalid(rvalid1), .rdata(rdata1));

    typedef struct {
        bit       sel;
        bit       wr;
        bit       bst;
        bit [7:0] addr;
        bit [7:0] wd;
        bit       intrude;
        int       exp_busy;
        int       exp_ack_at;
        int       exp_rv;
        bit [7:0] d0, d1, d2, d3;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         busy_n, ack_n, ack_at, rv_n, rv_first, rv_last;
        logic       b, a, rv;
        logic [7:0] rd;
        logic [7:0] got [4];
        logic [7:0] exp [4];
        exp = '{v.d0, v.d1, v.d2, v.d3};
        got = '{8'h00, 8'h00, 8'h00, 8'h00};
        busy_n = 0; ack_n = 0; ack_at = -1; rv_n = 0; rv_first = -1; rv_last = -1;
        rd = 8'h00;
        @(negedge clk);
        wren = v.wr; burst = v.bst; address = v.addr; wdata = v.wd;
        if (v.sel) req1 = 1'b1; else req0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            b  = v.sel ? busy1   : busy0;
            a  = v.sel ? ack1    : ack0;
            rv = v.sel ? rvalid1 : rvalid0;
            rd = v.sel ? rdata1  : rdata0;
            if (b) busy_n++;
            if (a) begin ack_n++; ack_at = c; end
            if (rv) begin
                if (rv_n < 4) got[rv_n] = rd;
                rv_n++;
                if (rv_first < 0) rv_first = c;
                rv_last = c;
            end
            if (c == 1) begin
                req0 = 1'b0; req1 = 1'b0;
                wren = 1'($urandom); burst = 1'($urandom);
                address = 8'($urandom); wdata = 8'($urandom);
                if (v.intrude) begin
                    wren = 1'b1; burst = 1'b0; address = v.addr; wdata = 8'hFF;
                    if (v.sel) req1 = 1'b1; else req0 = 1'b1;
                end
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        check($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_busy);
        check($sformatf("v%0d ack_count", idx), ack_n, 1);
        check($sformatf("v%0d ack_cycle", idx), ack_at, v.exp_ack_at);
        check($sformatf("v%0d rvalid_count", idx), rv_n, v.exp_rv);
        if (v.exp_rv > 0) begin
            check($sformatf("v%0d rvalid_first", idx), rv_first, v.exp_ack_at - v.exp_rv + 1);
            check($sformatf("v%0d rvalid_last", idx), rv_last, v.exp_ack_at);
            for (int i = 0; i < v.exp_rv && i < 4; i++)
                check($sformatf("v%0d beat%0d", idx, i), got[i], exp[i]);
            check($sformatf("v%0d rdata_hold", idx), rd, exp[v.exp_rv - 1]);
        end
    endtask

    initial begin
        int rv_seen, busy_seen;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; wren = 1'b0; burst = 1'b0;
        address = 8'h00; wdata = 8'h00;

        //          sel   wr    bst   addr   wd    intr  busy ack rv  d0..d3
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 3, 3, 1, 8'hA5, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hFE, 8'h11, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h22, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h44, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 1'b0, 6, 6, 4, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h9C, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 3, 3, 1, 8'h9C, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 3, 3, 1, 8'h9C, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h2F, 8'h00, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h32, 8'h77, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h30, 8'h5A, 1'b0, 3, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h2F, 8'h00, 1'b0, 6, 6, 4, 8'h00, 8'h5A, 8'h00, 8'h77};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h05, 8'h7E, 1'b0, 2, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 2, 2, 1, 8'h7E, 8'h00, 8'h00, 8'h00};

        repeat (2) @(negedge clk);
        check("rst busy0", busy0, 0);   check("rst ack0", ack0, 0);
        check("rst rvalid0", rvalid0, 0); check("rst rdata0", rdata0, 0);
        check("rst busy1", busy1, 0);   check("rst ack1", ack1, 0);
        check("rst rvalid1", rvalid1, 0); check("rst rdata1", rdata1, 0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Reset in the middle of a burst from 0xFE, right after beat 1 shows up
        @(negedge clk);
        wren = 1'b0; burst = 1'b1; address = 8'hFE; req1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req1 = 1'b0;
        end
        check("burst_rst beat1 rvalid", rvalid1, 1);
        check("burst_rst beat1 data", rdata1, 8'h22);
        #2 reset = 1'b0;
        #1;
        check("burst_rst busy", busy1, 0);
        check("burst_rst ack", ack1, 0);
        check("burst_rst rvalid", rvalid1, 0);
        check("burst_rst rdata", rdata1, 0);
        @(negedge clk);
        reset = 1'b1;
        rv_seen = 0; busy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rvalid1) rv_seen++;
            if (busy1) busy_seen++;
        end
        check("burst_rst late_beats", rv_seen, 0);
        check("burst_rst late_busy", busy_seen, 0);
        run_vec('{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 3, 3, 1, 8'h22, 8'h00, 8'h00, 8'h00}, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Byte-wide memory-side responder that answers the processor's data-memory requests through a req/ack handshake.
- Adds configurable wait states and a 4-beat burst read for vector loads.
- Sits between the multicycle datapath (initiator: address, write data, read/write strobes) and an internal 256x8 storage array.
- Replaces the fixed single-cycle memory so the control FSM can be verified against variable latency.

Parameters:
- ADDR_W, 8, address width; storage depth is 2^ADDR_W bytes.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, wait states inserted before each transfer (0 allowed).
- BURST_LEN, 4, beats returned by a burst read.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- wren  in  1  1 = write, 0 = read; captured with req.
- burst  in  1  1 = burst read of BURST_LEN bytes; ignored when wren=1.
- address  in  ADDR_W  start byte address; captured with req.
- wdata  in  DATA_W  write data; captured with req.
- busy  out  1  high from the cycle after request capture until return to IDLE.
- ack  out  1  one-cycle pulse marking completion of the whole request.
- rvalid  out  1  high for one cycle per returned read beat.
- rdata  out  DATA_W  read data; valid when rvalid=1, holds its last value otherwise.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the wait counter, beat counter and captured request registers clear.
  - busy=0, ack=0, rvalid=0, rdata=0.
  - Storage contents are NOT cleared.
  - A write not yet committed is dropped. A burst in progress is abandoned with no further beats.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - On an edge with req=1, capture address, wren, wdata and burst (forced to 0 if wren=1).
  - Go to WAIT if WAIT_CYCLES>0, else go straight to XFER. Clear the wait counter.
- WAIT:
  - Increment the wait counter each cycle.
  - Go to XFER on the edge where counter = WAIT_CYCLES-1.
- XFER, single write: mem[addr] <= wdata; go to DONE.
- XFER, single read: rdata <= mem[addr]; rvalid=1 for the following cycle; go to DONE.
- XFER, burst read:
  - One beat per cycle. Beat k registers mem[(addr+k) mod 2^ADDR_W] into rdata with rvalid=1 the following cycle, k = 0..BURST_LEN-1.
  - Addresses wrap modulo 2^ADDR_W (0xFF then 0x00).
  - No wait states between beats.
  - Go to DONE after beat BURST_LEN-1.
- DONE:
  - ack=1 for exactly this one cycle, coincident with the last rvalid for reads.
  - Unconditional return to IDLE.
- Latency, with E0 = the edge that samples req:
  - Single request: ack (and rvalid for reads) high in the cycle after edge E0+WAIT_CYCLES+1.
  - Burst: ack high with the final beat, at edge E0+WAIT_CYCLES+BURST_LEN.
- busy=1 in WAIT, XFER and DONE.
- req is ignored in every state except IDLE. No queuing; a req held through DONE is accepted in IDLE on the next edge.
- Inputs may change freely after capture; the captured copies are used.
- Simultaneous reset and req: reset wins.

Test Plan:
- WAIT_CYCLES=1: write req addr 0x10 wdata 0xA5, then read req addr 0x10 -> ack 2 cycles after each request edge; read gives rvalid=1 with rdata=0xA5; busy high for 3 cycles per request.
- Preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44; burst read at 0xFE -> rvalid on 4 consecutive cycles carrying 0x11, 0x22, 0x33, 0x44; ack only on the 0x44 beat.
- WAIT_CYCLES=0: read req at addr 0x05 holding 0x7E -> rvalid/ack in the cycle right after the edge after request capture; busy high for exactly 2 cycles.
- During a busy read at 0x20, pulse req with wren=1 addr 0x20 wdata 0xFF -> second request ignored; mem[0x20] unchanged; exactly one ack.
- Assert reset after beat 1 of a burst -> busy, ack, rvalid and rdata go 0 immediately; no further beats; a later read of 0xFF still returns 0x22.
- Burst=1 with wren=1, addr 0x30, wdata 0x5A -> treated as a single write: one ack, no rvalid, only mem[0x30] changes.
